// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU with the M extension:
//   - funct3 encodings of the base integer ops (mext = 0)
//   - funct3 encodings of the multiply/divide ops (mext = 1)
//   - state type of the top-level sequencing FSM
// No ports (package).
// ---------------------------------------------------------------------------
package alu_pkg;

    // Base integer ops, selected by funct3 when mext = 0
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Multiply/divide ops, selected by funct3 when mext = 1
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } alu_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// ---------------------------------------------------------------------------
// muldiv_iter
// Iterative multiply/divide datapath shared by all M-extension ops.
// Works on operand magnitudes for XLEN iterations (shift-add for multiply,
// restoring shift-subtract for divide) and applies the sign fix-up on the
// way out. The first iteration is performed on the start edge itself, so
// the final iteration happens XLEN-1 edges after start.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load operands and op (one-cycle pulse, M-op accepted)
//   funct3      M-op select (MUL..REMU), sampled only on start
//   a, b        operands (rs1, rs2), sampled only on start
//   done        high in the cycle whose clock edge performs the last iteration
//   result      sign-corrected result, valid once the last iteration is done
// ---------------------------------------------------------------------------
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;

    // Multiply: acc = {partial high, remaining multiplier}, opnd = multiplicand.
    // Divide:   acc = {partial remainder, remaining dividend/quotient}, opnd = divisor.
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic [CW-1:0]     count;
    logic              active;
    logic              is_div;
    logic              sel_upper;
    logic              neg;

    logic              sign_a, sign_b, neg_a, neg_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              start_neg, start_upper;

    logic              cur_is_div;
    logic [XLEN-1:0]   cur_opnd;
    logic [2*XLEN-1:0] cur_acc, next_acc;
    logic [XLEN:0]     add_sum, div_shift, div_diff;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_sel;

    // Operand signedness and magnitudes for the op being started.
    // MULHSU treats only rs1 as signed; MULHU/DIVU/REMU treat neither.
    // The remainder takes the dividend's sign, everything else the xor.
    always_comb begin
        if (funct3[2]) begin
            sign_a = ~funct3[0];
            sign_b = ~funct3[0];
        end else begin
            sign_a = (funct3[1:0] != 2'b11);
            sign_b = ~funct3[1];
        end
        neg_a       = sign_a & a[XLEN-1];
        neg_b       = sign_b & b[XLEN-1];
        mag_a       = neg_a ? -a : a;
        mag_b       = neg_b ? -b : b;
        start_neg   = (funct3[2] && funct3[1]) ? neg_a : (neg_a ^ neg_b);
        start_upper = funct3[2] ? funct3[1] : (funct3[1:0] != 2'b00);
    end

    // One iteration step. On start the step runs directly on the freshly
    // prepared operands, which keeps the total latency at XLEN+1.
    always_comb begin
        cur_is_div = start ? funct3[2] : is_div;
        cur_opnd   = start ? (funct3[2] ? mag_b : mag_a) : opnd;
        cur_acc    = start ? {{XLEN{1'b0}}, (funct3[2] ? mag_a : mag_b)} : acc;

        add_sum    = {1'b0, cur_acc[2*XLEN-1:XLEN]}
                   + (cur_acc[0] ? {1'b0, cur_opnd} : {(XLEN+1){1'b0}});

        div_shift  = cur_acc[2*XLEN-1:XLEN-1];
        div_diff   = div_shift - {1'b0, cur_opnd};

        if (cur_is_div) begin
            next_acc = {(div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0]),
                        cur_acc[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            next_acc = {add_sum, cur_acc[XLEN-1:1]};
        end
    end

    // Sign fix-up: the product is negated as a whole before picking a half,
    // whereas quotient and remainder are negated individually.
    always_comb begin
        prod_fix = neg ? -acc : acc;
        div_sel  = sel_upper ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        if (is_div) begin
            result = neg ? -div_sel : div_sel;
        end else begin
            result = sel_upper ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
        end
    end

    assign done = active && (count == CW'(XLEN - 1));

    // Iteration registers; acc freezes once the last iteration is done so the
    // result stays available for the write-back cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            opnd      <= '0;
            count     <= '0;
            active    <= 1'b0;
            is_div    <= 1'b0;
            sel_upper <= 1'b0;
            neg       <= 1'b0;
        end else if (start) begin
            acc       <= next_acc;
            opnd      <= cur_opnd;
            count     <= CW'(1);
            active    <= 1'b1;
            is_div    <= funct3[2];
            sel_upper <= start_upper;
            neg       <= start_neg;
        end else if (active) begin
            acc   <= next_acc;
            count <= count + CW'(1);
            if (done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mext.sv
// ---------------------------------------------------------------------------
// alu_mext
// Execute-stage ALU: single-cycle RV32I integer ops plus iterative RV32M
// multiply/divide, with valid/ready handshakes on input and output.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  input handshake; operands latched on accept
//   rs1, rs2            operands
//   funct3              op select
//   funct7              alternate-op bit (SUB, SRA)
//   mext                selects the multiply/divide op group
//   out_valid, out_ready output handshake
//   rd                  result, held stable while stalled
//   z                   rd == 0
// ---------------------------------------------------------------------------
module alu_mext
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    input  logic            funct7,
    input  logic            mext,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd,
    output logic            z
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    alu_state_t      state;
    logic            accept;
    logic            start;
    logic            div_zero, div_ovf, early;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] base_res;
    logic [XLEN-1:0] early_res;
    logic            mdu_done;
    logic [XLEN-1:0] mdu_result;

    // in_ready is forced low while reset is held.
    assign in_ready = rst_n && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign shamt    = rs2[SHW-1:0];

    // Base integer ops.
    always_comb begin
        base_res = '0;
        case (funct3)
            F3_ADD:  base_res = funct7 ? (rs1 - rs2) : (rs1 + rs2);
            F3_SLL:  base_res = rs1 << shamt;
            F3_SLT:  base_res = XLEN'($signed(rs1) < $signed(rs2));
            F3_SLTU: base_res = XLEN'(rs1 < rs2);
            F3_XOR:  base_res = rs1 ^ rs2;
            F3_SRL:  base_res = funct7 ? XLEN'($signed(rs1) >>> shamt) : (rs1 >> shamt);
            F3_OR:   base_res = rs1 | rs2;
            F3_AND:  base_res = rs1 & rs2;
            default: base_res = '0;
        endcase
    end

    // Divides whose result is fixed by the operands finish without iterating:
    // divide by zero, and signed overflow (most-negative / -1, DIV and REM).
    always_comb begin
        div_zero = (rs2 == '0);
        div_ovf  = !funct3[0] && (rs1 == MOST_NEG) && (rs2 == '1);
        early    = mext && funct3[2] && (div_zero || div_ovf);
        if (div_zero) begin
            early_res = funct3[1] ? rs1 : '1;
        end else begin
            early_res = funct3[1] ? '0 : rs1;
        end
    end

    assign start = accept && mext && !early;

    muldiv_iter #(
        .XLEN(XLEN)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .a      (rs1),
        .b      (rs2),
        .done   (mdu_done),
        .result (mdu_result)
    );

    // Sequencing FSM with registered result. A pop clears out_valid unless a
    // new result is written in the same cycle, which simply overrides it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            rd        <= '0;
            z         <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!mext) begin
                            rd        <= base_res;
                            z         <= (base_res == '0);
                            out_valid <= 1'b1;
                        end else if (early) begin
                            rd        <= early_res;
                            z         <= (early_res == '0);
                            out_valid <= 1'b1;
                        end else begin
                            state <= funct3[2] ? DIV : MUL;
                        end
                    end
                end
                MUL, DIV: begin
                    if (mdu_done) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    rd        <= mdu_result;
                    z         <= (mdu_result == '0);
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mext.sv
// ---------------------------------------------------------------------------
// tb_alu_mext
// Self-checking bench for alu_mext (XLEN = 32): directed vectors, randomized
// operations against an arithmetic reference model, backpressure and
// mid-operation reset.
// ---------------------------------------------------------------------------
module tb_alu_mext;
    import alu_pkg::*;

    localparam int XLEN = 32;
    localparam int MLAT = XLEN + 1;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [2:0]      funct3;
    logic            funct7;
    logic            mext;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] rd;
    logic            z;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  f3;
        logic        f7;
        logic        m;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [5:0]  lat;
    } vec_t;

    alu_mext #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .mext      (mext),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd        (rd),
        .z         (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result from plain wide arithmetic on the architectural rules.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic f7, input logic m,
                                          input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb;
        logic [63:0] ua, ub, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = 64'd0;
        if (!m) begin
            case (f3)
                F3_ADD:  r = f7 ? (ua - ub) : (ua + ub);
                F3_SLL:  r = ua << b[4:0];
                F3_SLT:  r = (sa < sb) ? 64'd1 : 64'd0;
                F3_SLTU: r = (ua < ub) ? 64'd1 : 64'd0;
                F3_XOR:  r = ua ^ ub;
                F3_SRL:  r = f7 ? 64'(sa >>> b[4:0]) : (ua >> b[4:0]);
                F3_OR:   r = ua | ub;
                default: r = ua & ub;
            endcase
        end else begin
            case (f3)
                F3_MUL:    r = 64'(sa * sb);
                F3_MULH:   r = 64'(sa * sb) >> 32;
                F3_MULHSU: r = 64'(sa * longint'(ub)) >> 32;
                F3_MULHU:  r = (ua * ub) >> 32;
                F3_DIV:    if (b == 32'd0) r = '1; else r = 64'(sa / sb);
                F3_DIVU:   if (b == 32'd0) r = '1; else r = ua / ub;
                F3_REM:    if (b == 32'd0) r = ua; else r = 64'(sa % sb);
                default:   if (b == 32'd0) r = ua; else r = ua % ub;
            endcase
        end
        return r[31:0];
    endfunction

    function automatic int model_latency(input logic [2:0] f3, input logic m,
                                         input logic [31:0] a, input logic [31:0] b);
        if (!m || !f3[2]) return m ? MLAT : 1;
        if (b == 32'd0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return MLAT;
    endfunction

    function automatic vec_t mk(input logic [2:0] f3, input logic f7, input logic m,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] e, input logic [5:0] lat);
        vec_t v;
        v.f3 = f3; v.f7 = f7; v.m = m; v.a = a; v.b = b; v.exp = e; v.lat = lat;
        return v;
    endfunction

    // Drives one operation with out_ready high and waits (bounded) for the
    // result. lat counts cycles from accept to out_valid, -1 on timeout.
    task automatic do_op(input logic [2:0] f3, input logic f7, input logic m,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic zz,
                         output int lat, output bit ready_leak);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b1;
        funct3 = f3; funct7 = f7; mext = m; rs1 = a; rs2 = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        ready_leak = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) ready_leak = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
        res = rd;
        zz = z;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        rs1 = '0; rs2 = '0; funct3 = '0; funct7 = 1'b0; mext = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (rd !== '0) begin errors++; $display("[TB] FAIL reset_rd: got %h expected 0", rd); end
        checks++;
        if (z !== 1'b0) begin errors++; $display("[TB] FAIL reset_z: got %b expected 0", z); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_base_directed();
        vec_t tbl[$];
        logic [31:0] res;
        logic zz;
        int lat;
        bit leak;
        tbl.push_back(mk(F3_ADD,  1'b0, 1'b0, 32'd20, 32'd30, 32'd50, 6'd1));
        tbl.push_back(mk(F3_ADD,  1'b1, 1'b0, 32'd20, 32'd20, 32'd0, 6'd1));
        tbl.push_back(mk(F3_ADD,  1'b1, 1'b0, 32'd8, 32'd3, 32'd5, 6'd1));
        tbl.push_back(mk(F3_SLL,  1'b0, 1'b0, 32'd8, 32'd3, 32'd64, 6'd1));
        tbl.push_back(mk(F3_SRL,  1'b1, 1'b0, 32'h8000_0000, 32'd4, 32'hF800_0000, 6'd1));
        tbl.push_back(mk(F3_SRL,  1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000, 6'd1));
        tbl.push_back(mk(F3_SLT,  1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd1, 6'd1));
        tbl.push_back(mk(F3_SLTU, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 6'd1));
        tbl.push_back(mk(F3_XOR,  1'b0, 1'b0, 32'd8, 32'd3, 32'd11, 6'd1));
        tbl.push_back(mk(F3_XOR,  1'b1, 1'b0, 32'd8, 32'd3, 32'd11, 6'd1));
        tbl.push_back(mk(F3_AND,  1'b0, 1'b0, 32'd20, 32'd30, 32'd20, 6'd1));
        tbl.push_back(mk(F3_OR,   1'b0, 1'b0, 32'd20, 32'd30, 32'd30, 6'd1));
        tbl.push_back(mk(F3_SLL,  1'b1, 1'b0, 32'd1, 32'd35, 32'd8, 6'd1));
        foreach (tbl[i]) begin
            do_op(tbl[i].f3, tbl[i].f7, tbl[i].m, tbl[i].a, tbl[i].b, res, zz, lat, leak);
            checks++;
            if (res !== tbl[i].exp) begin errors++; $display("[TB] FAIL base_dir[%0d] rd: got %h expected %h", i, res, tbl[i].exp); end
            checks++;
            if (zz !== (tbl[i].exp == 32'd0)) begin errors++; $display("[TB] FAIL base_dir[%0d] z: got %b expected %b", i, zz, tbl[i].exp == 32'd0); end
            checks++;
            if (lat != int'(tbl[i].lat)) begin errors++; $display("[TB] FAIL base_dir[%0d] latency: got %0d expected %0d", i, lat, tbl[i].lat); end
        end
    endtask

    task automatic test_mext_directed();
        vec_t tbl[$];
        logic [31:0] res;
        logic zz;
        int lat;
        bit leak;
        tbl.push_back(mk(F3_MUL,    1'b0, 1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 6'd33));
        tbl.push_back(mk(F3_MULH,   1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 6'd33));
        tbl.push_back(mk(F3_MULHU,  1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 6'd33));
        tbl.push_back(mk(F3_MULHSU, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd33));
        tbl.push_back(mk(F3_DIV,    1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 6'd33));
        tbl.push_back(mk(F3_REM,    1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 6'd33));
        tbl.push_back(mk(F3_DIVU,   1'b0, 1'b1, 32'd100, 32'd0, 32'hFFFF_FFFF, 6'd1));
        tbl.push_back(mk(F3_REMU,   1'b0, 1'b1, 32'd100, 32'd0, 32'd100, 6'd1));
        tbl.push_back(mk(F3_DIV,    1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 6'd1));
        tbl.push_back(mk(F3_REM,    1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 6'd1));
        tbl.push_back(mk(F3_DIVU,   1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 6'd33));
        foreach (tbl[i]) begin
            do_op(tbl[i].f3, tbl[i].f7, tbl[i].m, tbl[i].a, tbl[i].b, res, zz, lat, leak);
            checks++;
            if (res !== tbl[i].exp) begin errors++; $display("[TB] FAIL mext_dir[%0d] rd: got %h expected %h", i, res, tbl[i].exp); end
            checks++;
            if (zz !== (tbl[i].exp == 32'd0)) begin errors++; $display("[TB] FAIL mext_dir[%0d] z: got %b expected %b", i, zz, tbl[i].exp == 32'd0); end
            checks++;
            if (lat != int'(tbl[i].lat)) begin errors++; $display("[TB] FAIL mext_dir[%0d] latency: got %0d expected %0d", i, lat, tbl[i].lat); end
            checks++;
            if (leak !== 1'b0) begin errors++; $display("[TB] FAIL mext_dir[%0d] in_ready_busy: got 1 expected 0", i); end
        end
    endtask

    task automatic test_base_random();
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] a, b, exp, res;
        logic zz;
        int lat;
        bit leak;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            f7 = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = 32'($urandom_range(0, 40));
                default: b = $urandom;
            endcase
            exp = model(f3, f7, 1'b0, a, b);
            do_op(f3, f7, 1'b0, a, b, res, zz, lat, leak);
            checks++;
            if (res !== exp) begin errors++; $display("[TB] FAIL base_rand[%0d] f3=%0d f7=%b rd: got %h expected %h", i, f3, f7, res, exp); end
            checks++;
            if (zz !== (exp == 32'd0)) begin errors++; $display("[TB] FAIL base_rand[%0d] z: got %b expected %b", i, zz, exp == 32'd0); end
            checks++;
            if (lat != 1) begin errors++; $display("[TB] FAIL base_rand[%0d] latency: got %0d expected 1", i, lat); end
        end
    endtask

    task automatic test_mext_random();
        logic [2:0]  f3;
        logic [31:0] a, b, exp, res;
        logic zz;
        int lat, elat;
        bit leak;
        for (int i = 0; i < 32; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       b = 32'($urandom_range(1, 20));
                3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
                default: b = $urandom;
            endcase
            exp  = model(f3, 1'b0, 1'b1, a, b);
            elat = model_latency(f3, 1'b1, a, b);
            do_op(f3, 1'b0, 1'b1, a, b, res, zz, lat, leak);
            checks++;
            if (res !== exp) begin errors++; $display("[TB] FAIL mext_rand[%0d] f3=%0d a=%h b=%h rd: got %h expected %h", i, f3, a, b, res, exp); end
            checks++;
            if (zz !== (exp == 32'd0)) begin errors++; $display("[TB] FAIL mext_rand[%0d] z: got %b expected %b", i, zz, exp == 32'd0); end
            checks++;
            if (lat != elat) begin errors++; $display("[TB] FAIL mext_rand[%0d] latency: got %0d expected %0d", i, lat, elat); end
            checks++;
            if (leak !== 1'b0) begin errors++; $display("[TB] FAIL mext_rand[%0d] in_ready_busy: got 1 expected 0", i); end
        end
    endtask

    task automatic test_backpressure();
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        funct3 = F3_ADD; funct7 = 1'b0; mext = 1'b0; rs1 = 32'd20; rs2 = 32'd30;
        in_valid = 1'b1;
        @(negedge clk);
        // Second op presented while the first result is stalled
        funct3 = F3_ADD; funct7 = 1'b1; rs1 = 32'd9; rs2 = 32'd4;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold[%0d] out_valid: got %b expected 1", k, out_valid); end
            checks++;
            if (rd !== 32'd50) begin errors++; $display("[TB] FAIL hold[%0d] rd: got %h expected %h", k, rd, 32'd50); end
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold[%0d] in_ready: got %b expected 0", k, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL pop_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL second_out_valid: got %b expected 1", out_valid); end
        checks++;
        if (rd !== 32'd5) begin errors++; $display("[TB] FAIL second_rd: got %h expected %h", rd, 32'd5); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drained_out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid_op();
        int guard;
        bit spurious;
        logic [31:0] res;
        logic zz;
        int lat;
        bit leak;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b1;
        funct3 = F3_DIV; funct7 = 1'b0; mext = 1'b1; rs1 = 32'hFFFF_FFF9; rs2 = 32'd2;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL div_busy_in_ready: got %b expected 0", in_ready); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (rd !== 32'd0) begin errors++; $display("[TB] FAIL abort_rd: got %h expected 0", rd); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL abort_in_ready: got %b expected 0", in_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        spurious = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) spurious = 1'b1;
        end
        checks++;
        if (spurious !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_output: got 1 expected 0"); end
        do_op(F3_ADD, 1'b0, 1'b0, 32'd1, 32'd1, res, zz, lat, leak);
        checks++;
        if (res !== 32'd2) begin errors++; $display("[TB] FAIL post_reset_rd: got %h expected %h", res, 32'd2); end
        checks++;
        if (lat != 1) begin errors++; $display("[TB] FAIL post_reset_latency: got %0d expected 1", lat); end
    endtask

    initial begin
        test_reset();
        test_base_directed();
        test_mext_directed();
        test_base_random();
        test_mext_random();
        test_backpressure();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/alu_mext.md
Name: alu_mext

Overview:
Next-generation execute-stage ALU for the RISC-V core.
- Parametrised in XLEN.
- Adds the RV32M multiply/divide operations as a multi-cycle iterative unit.
- Adds a valid/ready handshake on both input and output so the pipeline can stall.
- Base RV32I ops complete in one cycle; M-ops occupy the unit until done.

Parameters:
XLEN, 32, datapath width (must be power of two, >= 8)
SHW, $clog2(XLEN), shift-amount width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  operation presented
in_ready  out  1  unit can accept operation this cycle
rs1  in  XLEN  operand A
rs2  in  XLEN  operand B
funct3  in  3  RISC-V funct3
funct7  in  1  alternate-op bit (instr[30]): SUB, SRA
mext  in  1  M-extension select (instr[25]); when 1, funct3 selects MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
rd  out  XLEN  result
z  out  1  rd == 0

Behaviour:
- Reset: state IDLE, out_valid=0, rd=0, z=0, in_ready=0 while rst_n low. Asserting rst_n mid-operation aborts the op with no output produced.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept = in_valid && in_ready. Operands and op are latched on accept; they are not sampled again.
- Output hold: while out_valid && !out_ready, rd/z stay stable and no new op is accepted.
- Output pop: out_valid clears on out_valid && out_ready unless a new result is written in the same cycle.
- Base ops (mext=0) are registered with latency 1: accept in cycle N, out_valid in cycle N+1.
  - ADD/SUB: wraps mod 2^XLEN.
  - SLL/SRL/SRA: shift by rs2[SHW-1:0].
  - SLT: signed compare. SLTU: unsigned compare. Both yield 0 or 1.
  - XOR/OR/AND: bitwise.
  - funct7 is ignored for funct3 other than 000/101.
- State machine: IDLE -> MUL | DIV on accept of an M-op -> DONE when the iteration count reaches XLEN -> IDLE when the result is written (out_valid=1).
- MUL:
  - Shift-add over operand magnitudes, XLEN iterations, 2*XLEN product.
  - Sign correction per op: MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
  - Latency XLEN+1.
- DIV: restoring, XLEN iterations, on magnitudes, with sign fix-up (quotient sign = sign(a)^sign(b); remainder sign = sign(a)). Latency XLEN+1.
- Divide early-out, latency 1:
  - Divide by zero: quotient = all ones, remainder = rs1.
  - Signed overflow (rs1 = most-negative, rs2 = -1, DIV/REM only): quotient = rs1, remainder = 0.
- z is computed from the final rd value for every op.

Decomposition:
- Package alu_pkg:
  - funct3 constants for base ops (F3_ADD..F3_AND).
  - funct3 constants for M-ops (F3_MUL..F3_REMU).
  - State enum alu_state_t {IDLE, MUL, DIV, DONE}.
- One sub-module muldiv_iter:
  - Shared iterative shift/add/subtract datapath plus iteration counter.
  - Start/done interface.
  - Top level holds the base ALU, the handshake and the state machine.

Test Plan:
- ADD 20+30 -> rd=50, z=0, one cycle after accept. SUB 20-20 -> rd=0, z=1. SUB 8-3 -> 5.
- SLL 8<<3 -> 64. SRA 0x8000_0000>>>4 -> 0xF800_0000. SRL of the same -> 0x0800_0000. SLT -1<2 -> 1. SLTU of the same operands -> 0. XOR 8^3 -> 11. AND/OR 20,30 -> 20 / 30.
- MUL 7×-3 -> 0xFFFF_FFEB. MULH -1×-1 -> 0. MULHU 0xFFFF_FFFF² -> 0xFFFF_FFFE. Each: out_valid exactly 33 cycles after accept; in_ready=0 throughout.
- DIV -7/2 -> -3. REM -7/2 -> -1. DIVU 100/0 -> 0xFFFF_FFFF. REMU 100/0 -> 100. DIV 0x8000_0000/-1 -> 0x8000_0000 with latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after ADD completes -> rd stable, in_ready=0, a second in_valid is not accepted. Then out_ready=1 -> the second op is accepted that cycle.
- Reset: drop rst_n during cycle 10 of a DIV -> out_valid=0, rd=0 immediately. After release, ADD 1+1 -> 2 with normal latency.
